// File: rtl/vx_tex_agent_pkg.sv
// vx_tex_agent_pkg
//   Shared texture-agent definitions: the per-core configuration, the derived
//   widths (warp id, pending-table index, bus tag), the pending-entry record,
//   and the helpers that build and split a texture-bus tag.
//   Tag layout: {uuid, idx}, with the uuid in the high bits and the
//   pending-table index in the low IDX_W bits.
package vx_tex_agent_pkg;

  localparam int NUM_LANES    = 4;
  localparam int NUM_WARPS    = 4;
  localparam int PENDING_SIZE = 8;   // must be a power of two
  localparam int UUID_WIDTH   = 44;
  localparam int STAGE_BITS   = 1;

  localparam int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int IDX_W     = $clog2(PENDING_SIZE);
  localparam int CNT_W     = IDX_W + 1;
  localparam int TAG_WIDTH = UUID_WIDTH + IDX_W;

  // Writeback context held while a request is out at the texture unit.
  typedef struct packed {
    logic [WID_W-1:0]     wid;
    logic [NUM_LANES-1:0] mask;
    logic [31:0]          pc;
    logic [4:0]           rd;
  } pending_entry_t;

  function automatic logic [TAG_WIDTH-1:0] make_tag(input logic [UUID_WIDTH-1:0] uuid,
                                                    input logic [IDX_W-1:0]      idx);
    return {uuid, idx};
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_WIDTH-1:0] tag);
    return tag[IDX_W-1:0];
  endfunction

  function automatic logic [UUID_WIDTH-1:0] tag_uuid(input logic [TAG_WIDTH-1:0] tag);
    return tag[TAG_WIDTH-1 -: UUID_WIDTH];
  endfunction

endpackage

// File: rtl/vx_tex_agent_pending_table.sv
// tex_pending_table
//   Tracks outstanding texture requests. Holds an allocated bitmap, a
//   lowest-free-index priority encoder, per-index writeback context, the
//   number of allocated entries and a full flag.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   alloc_en             allocate alloc_idx and store alloc_entry this cycle
//   alloc_entry          context written on allocation
//   alloc_idx            lowest index free at the start of the cycle
//   full                 every index allocated
//   release_en           free release_idx this cycle
//   release_idx          index being returned
//   release_entry        context stored at release_idx (combinational read)
//   count                number of allocated entries
module tex_pending_table
  import vx_tex_agent_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_en,
  input  pending_entry_t   alloc_entry,
  output logic [IDX_W-1:0] alloc_idx,
  output logic             full,
  input  logic             release_en,
  input  logic [IDX_W-1:0] release_idx,
  output pending_entry_t   release_entry,
  output logic [CNT_W-1:0] count
);

  logic [PENDING_SIZE-1:0] alloc_bitmap_reg;
  logic [PENDING_SIZE-1:0] alloc_bitmap_next;
  logic [PENDING_SIZE-1:0] alloc_onehot;
  logic [PENDING_SIZE-1:0] release_onehot;
  logic [CNT_W-1:0]        count_reg;
  logic [CNT_W-1:0]        count_next;

  pending_entry_t entries [PENDING_SIZE];

  // Lowest free index, scanning from the top so the lowest hit wins.
  // Only the registered bitmap is consulted, so an index released this
  // cycle cannot be handed out again until the next one.
  always_comb begin
    alloc_idx = '0;
    for (int i = PENDING_SIZE - 1; i >= 0; i--) begin
      if (!alloc_bitmap_reg[i]) alloc_idx = IDX_W'(i);
    end
  end

  for (genvar gi = 0; gi < PENDING_SIZE; gi++) begin : g_onehot
    assign alloc_onehot[gi]   = alloc_en   && (alloc_idx   == IDX_W'(gi));
    assign release_onehot[gi] = release_en && (release_idx == IDX_W'(gi));
  end

  assign full              = &alloc_bitmap_reg;
  assign alloc_bitmap_next = (alloc_bitmap_reg | alloc_onehot) & ~release_onehot;
  assign count_next        = count_reg + CNT_W'(alloc_en) - CNT_W'(release_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_bitmap_reg <= '0;
      count_reg        <= '0;
    end else begin
      alloc_bitmap_reg <= alloc_bitmap_next;
      count_reg        <= count_next;
    end
  end

  // Context storage is not reset; only the bitmap says what is live.
  always_ff @(posedge clk) begin
    if (alloc_en) entries[alloc_idx] <= alloc_entry;
  end

  assign release_entry = entries[release_idx];
  assign count         = count_reg;

  // A response naming an index that is not allocated is a protocol error
  // (double free or corrupted tag).
  always @(posedge clk) begin
    if (!reset && release_en) begin
      assert (alloc_bitmap_reg[release_idx])
        else $error("tex_pending_table: release of unallocated idx %0d", release_idx);
    end
  end

endmodule

// File: rtl/vx_tex_agent.sv
// vx_tex_agent
//   Core-side texture-bus initiator. Execute-stage sample requests allocate a
//   pending-table slot and are forwarded to the texture unit tagged with
//   {uuid, idx}; responses, in any order, look their context up by idx and
//   leave as commit packets.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   exe_req_*                        request from execute (valid/ready, context, payload)
//   tex_req_*                        request to texture unit (valid/ready, payload, tag)
//   tex_rsp_*                        response from texture unit (valid/ready, texels, tag)
//   commit_*                         writeback packet (valid/ready, context, data)
//   pending_count                    number of allocated pending entries
module vx_tex_agent
  import vx_tex_agent_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        exe_req_valid,
  output logic                        exe_req_ready,
  input  logic [UUID_WIDTH-1:0]       exe_req_uuid,
  input  logic [WID_W-1:0]            exe_req_wid,
  input  logic [31:0]                 exe_req_pc,
  input  logic [4:0]                  exe_req_rd,
  input  logic [NUM_LANES-1:0]        exe_req_mask,
  input  logic [STAGE_BITS-1:0]       exe_req_stage,
  input  logic [2*NUM_LANES*32-1:0]   exe_req_coords,
  input  logic [NUM_LANES*32-1:0]     exe_req_lod,

  output logic                        tex_req_valid,
  input  logic                        tex_req_ready,
  output logic [NUM_LANES-1:0]        tex_req_mask,
  output logic [STAGE_BITS-1:0]       tex_req_stage,
  output logic [2*NUM_LANES*32-1:0]   tex_req_coords,
  output logic [NUM_LANES*32-1:0]     tex_req_lod,
  output logic [TAG_WIDTH-1:0]        tex_req_tag,

  input  logic                        tex_rsp_valid,
  output logic                        tex_rsp_ready,
  input  logic [NUM_LANES*32-1:0]     tex_rsp_texels,
  input  logic [TAG_WIDTH-1:0]        tex_rsp_tag,

  output logic                        commit_valid,
  input  logic                        commit_ready,
  output logic [UUID_WIDTH-1:0]       commit_uuid,
  output logic [WID_W-1:0]            commit_wid,
  output logic [NUM_LANES-1:0]        commit_mask,
  output logic [31:0]                 commit_pc,
  output logic [4:0]                  commit_rd,
  output logic [NUM_LANES*32-1:0]     commit_data,

  output logic [CNT_W-1:0]            pending_count
);

  logic             table_full;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] rsp_idx;
  logic             exe_fire;
  logic             rsp_fire;
  pending_entry_t   alloc_entry;
  pending_entry_t   release_entry;

  // Request pipe register
  logic                      tex_req_valid_reg;
  logic [NUM_LANES-1:0]      tex_req_mask_reg;
  logic [STAGE_BITS-1:0]     tex_req_stage_reg;
  logic [2*NUM_LANES*32-1:0] tex_req_coords_reg;
  logic [NUM_LANES*32-1:0]   tex_req_lod_reg;
  logic [TAG_WIDTH-1:0]      tex_req_tag_reg;

  // Commit pipe register
  logic                      commit_valid_reg;
  logic [UUID_WIDTH-1:0]     commit_uuid_reg;
  pending_entry_t            commit_entry_reg;
  logic [NUM_LANES*32-1:0]   commit_data_reg;

  // Accept only when a slot is free and the request register is empty or
  // draining this cycle, so the register never overwrites unsent data.
  assign exe_req_ready = !table_full && (!tex_req_valid_reg || tex_req_ready);
  assign exe_fire      = exe_req_valid && exe_req_ready;

  assign tex_rsp_ready = !commit_valid_reg || commit_ready;
  assign rsp_fire      = tex_rsp_valid && tex_rsp_ready;
  assign rsp_idx       = tag_idx(tex_rsp_tag);

  assign alloc_entry = '{wid: exe_req_wid, mask: exe_req_mask, pc: exe_req_pc, rd: exe_req_rd};

  tex_pending_table u_table (
    .clk           (clk),
    .reset         (reset),
    .alloc_en      (exe_fire),
    .alloc_entry   (alloc_entry),
    .alloc_idx     (alloc_idx),
    .full          (table_full),
    .release_en    (rsp_fire),
    .release_idx   (rsp_idx),
    .release_entry (release_entry),
    .count         (pending_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tex_req_valid_reg <= 1'b0;
    end else if (exe_fire) begin
      tex_req_valid_reg <= 1'b1;
    end else if (tex_req_ready) begin
      tex_req_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (exe_fire) begin
      tex_req_mask_reg   <= exe_req_mask;
      tex_req_stage_reg  <= exe_req_stage;
      tex_req_coords_reg <= exe_req_coords;
      tex_req_lod_reg    <= exe_req_lod;
      tex_req_tag_reg    <= make_tag(exe_req_uuid, alloc_idx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_valid_reg <= 1'b0;
    end else if (rsp_fire) begin
      commit_valid_reg <= 1'b1;
    end else if (commit_ready) begin
      commit_valid_reg <= 1'b0;
    end
  end

  // The uuid travels with the tag, so it is taken from the response rather
  // than stored in the table.
  always_ff @(posedge clk) begin
    if (rsp_fire) begin
      commit_uuid_reg  <= tag_uuid(tex_rsp_tag);
      commit_entry_reg <= release_entry;
      commit_data_reg  <= tex_rsp_texels;
    end
  end

  assign tex_req_valid  = tex_req_valid_reg;
  assign tex_req_mask   = tex_req_mask_reg;
  assign tex_req_stage  = tex_req_stage_reg;
  assign tex_req_coords = tex_req_coords_reg;
  assign tex_req_lod    = tex_req_lod_reg;
  assign tex_req_tag    = tex_req_tag_reg;

  assign commit_valid = commit_valid_reg;
  assign commit_uuid  = commit_uuid_reg;
  assign commit_wid   = commit_entry_reg.wid;
  assign commit_mask  = commit_entry_reg.mask;
  assign commit_pc    = commit_entry_reg.pc;
  assign commit_rd    = commit_entry_reg.rd;
  assign commit_data  = commit_data_reg;

endmodule

// File: doc/vx_tex_agent.md
# vx_tex_agent

Core-side initiator of the texture bus: accepts texture-sample instructions from the execute stage, records per-request writeback context in a pending table, issues requests to the texture unit with a table-index tag, and turns out-of-order texture responses back into commit packets. Sits between the SFU dispatch path and the texture unit's request/response channels, one instance per core.

## Interface
- NUM_LANES, 4, threads per request
- NUM_WARPS, 4, warps per core (WID_W = max(1, clog2(NUM_WARPS)))
- PENDING_SIZE, 8, max outstanding requests, power of two (IDX_W = clog2(PENDING_SIZE))
- UUID_WIDTH, 44, instruction uuid width
- STAGE_BITS, 1, texture stage select width
- TAG_WIDTH, UUID_WIDTH+IDX_W, texture-bus tag width (derived)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- exe_req_valid / exe_req_ready  in / out  1  execute request handshake
- exe_req_uuid, exe_req_wid, exe_req_pc, exe_req_rd  in  UUID_WIDTH, WID_W, 32, 5  writeback context
- exe_req_mask  in  NUM_LANES  active lanes
- exe_req_stage  in  STAGE_BITS  texture stage
- exe_req_coords  in  2×NUM_LANES×32  u,v per lane
- exe_req_lod  in  NUM_LANES×32  lod per lane
- tex_req_valid / tex_req_ready  out / in  1  texture request handshake
- tex_req_mask, tex_req_stage, tex_req_coords, tex_req_lod  out  as exe_*  forwarded payload
- tex_req_tag  out  TAG_WIDTH  {uuid, idx}
- tex_rsp_valid / tex_rsp_ready  in / out  1  texture response handshake
- tex_rsp_texels  in  NUM_LANES×32  sampled texels
- tex_rsp_tag  in  TAG_WIDTH  returned tag
- commit_valid / commit_ready  out / in  1  writeback handshake
- commit_uuid, commit_wid, commit_mask, commit_pc, commit_rd  out  writeback context from table
- commit_data  out  NUM_LANES×32  texels
- pending_count  out  IDX_W+1  allocated entries

## Operation
- Pending table: PENDING_SIZE entries of {wid, mask, pc, rd}, plus an allocated bitmap.
- Request path: exe_req_ready = table not full AND request register can load (empty or tex_req_ready). On fire: allocate the lowest-numbered free index, write the entry, set the bit, and load the request register with payload and tag = {exe_req_uuid, idx}.
- Response path: idx = tex_rsp_tag[IDX_W-1:0]. On fire: read the entry, load the commit register with context, texels, and uuid = tex_rsp_tag[TAG_WIDTH-1 -: UUID_WIDTH]. Clear the bit in the same cycle.
- tex_rsp_ready = commit register empty OR commit_ready.
- Simultaneous alloc and release: both take effect. The allocator picks only from indices free at the start of the cycle, so a released index is never reused in the same cycle. pending_count next = count + alloc − release.
- Full: when all bits are set, exe_req_ready = 0. A release in that cycle does not raise ready until the next cycle.
- Responses may return in any order. A response to an unallocated idx is an error: a simulation assertion fires, and behaviour is undefined.

## Timing
- Reset (async) clears the bitmap, pending_count, tex_req_valid, and commit_valid. Payload registers are not reset.
- Immediately after reset: exe_req_ready = 1 and tex_rsp_ready = 1.
- exe fire → tex_req_valid next cycle (1-cycle latency).
- tex_rsp fire → commit_valid next cycle (1-cycle latency).
- Both paths sustain 1 transfer per cycle under continuous ready.
- Valid/ready: a source holds valid and stable data until ready. Outputs never deassert valid without a fire.
- Reset asserted mid-operation drops all in-flight requests and entries. No commit is produced for them.

## Structure
- The following go in the shared texture package: IDX_W derivation, the tag layout (uuid high, idx low), and the pending-entry struct.
- Sub-module tex_pending_table holds the bitmap, a lowest-free priority encoder, entry storage, the count, the full flag, and the double-free/invalid-release assertion.
- The top level contains the two output pipe registers and the handshake logic.

## Test plan
- Single request, uuid=5, wid=2, mask=4'b1011, rd=7: tex_req_tag = {5, 0} one cycle later. Respond with texels 0xA..0xD and tag {5, 0}: commit with wid=2, rd=7, mask=4'b1011, data 0xA..0xD. pending_count returns to 0.
- Issue 8 requests with tex_req_ready=1: tags have idx 0..7 and exe_req_ready=0 on the 9th. Respond with idx 3: exe_req_ready rises the cycle after, and the next tag has idx 3.
- Respond out of order (idx 2, 0, 1): commits appear in order 2, 0, 1, each with its own context.
- Same-cycle alloc with table at 7/8 and release of idx 4: the new request gets the remaining free idx, not 4. pending_count stays 7.
- Backpressure: hold commit_ready=0 for 5 cycles. tex_rsp_ready drops after the first response, with no loss or duplication. Hold tex_req_ready=0: tex_req_valid and payload stay stable.
- Assert reset with 3 outstanding requests: all valids go to 0 and pending_count = 0 asynchronously. After release, the first new request gets idx 0.
